// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the regfile write-port arbiter.
// Widths, FSM encodings and the queued result bundle.
package wb_port_arbiter_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 32;
  localparam int PC_W  = 32;

  typedef enum logic [1:0] {
    WBA_IDLE  = 2'd0,
    WBA_WAIT  = 2'd1,
    WBA_FORCE = 2'd2
  } wba_state_e;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [RF_AW-1:0] waddr;
    logic [RF_DW-1:0] wdata;
  } wb_res_t;

  localparam int RES_W = $bits(wb_res_t);

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO holding long-latency results
// until they win the regfile write port.
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [RES_W-1:0] push_data,
  input  logic             pop,
  output logic [RES_W-1:0] head,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);

  logic [RES_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between writeback and the
// long-latency unit, forcing a stall when results starve.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        pipe_wren_i,
  input  logic [4:0]  pipe_waddr_i,
  input  logic [31:0] pipe_wdata_i,
  input  logic [31:0] pipe_pc_i,
  input  logic        lu_valid_i,
  output logic        lu_ready_o,
  input  logic [4:0]  lu_waddr_i,
  input  logic [31:0] lu_wdata_i,
  input  logic [31:0] lu_pc_i,
  output logic        pipe_stall_o,
  output logic        rf_wren_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  wba_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rdy_q;
  logic [CW-1:0] fifo_count;
  logic [RES_W-1:0] fifo_head_raw;
  wb_res_t    fifo_head;
  wb_res_t    lu_res;
  wb_res_t    wr_sel;
  logic       push, fifo_one;
  logic       grant_pipe, grant_fifo;

  assign lu_res     = '{pc: lu_pc_i, waddr: lu_waddr_i, wdata: lu_wdata_i};
  assign fifo_head  = wb_res_t'(fifo_head_raw);
  assign fifo_one   = (fifo_count == CW'(1));
  // Ready is held low until the first edge after reset releases.
  assign lu_ready_o = rdy_q && (fifo_count < CW'(DEPTH));
  assign push       = lu_valid_i && lu_ready_o && !flush_i;

  wb_result_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_i),
    .push      (push),
    .push_data (lu_res),
    .pop       (grant_fifo),
    .head      (fifo_head_raw),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WBA_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = WBA_IDLE;
    end else begin
      unique case (state_q)
        WBA_IDLE:  if (push) state_d = WBA_WAIT;
        WBA_WAIT: begin
          if (pipe_wren_i) begin
            if (cnt_q >= LIM - 4'd1) state_d = WBA_FORCE;
          end else if (fifo_one && !push) begin
            state_d = WBA_IDLE;
          end
        end
        WBA_FORCE: begin
          if (fifo_one && !push) state_d = WBA_IDLE;
          else                   state_d = WBA_WAIT;
        end
        default:   state_d = WBA_IDLE;
      endcase
    end
  end

  always_comb begin
    grant_pipe = 1'b0;
    grant_fifo = 1'b0;
    if (flush_i) begin
      grant_pipe = pipe_wren_i;
    end else begin
      unique case (state_q)
        WBA_IDLE:  grant_pipe = pipe_wren_i;
        WBA_WAIT: begin
          grant_pipe = pipe_wren_i;
          grant_fifo = !pipe_wren_i;
        end
        WBA_FORCE: grant_fifo = 1'b1;
        default:   grant_pipe = 1'b0;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flush_i || grant_fifo) begin
      cnt_d = '0;
    end else if (state_q == WBA_WAIT && grant_pipe) begin
      if (cnt_q < LIM) cnt_d = cnt_q + 4'd1;
    end
  end

  always_comb begin
    wr_sel = '0;
    if (grant_pipe) begin
      wr_sel = '{pc: pipe_pc_i, waddr: pipe_waddr_i,
                 wdata: pipe_wdata_i};
    end else if (grant_fifo) begin
      wr_sel = fifo_head;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      rdy_q        <= 1'b0;
      pipe_stall_o <= 1'b0;
      rf_wren_o    <= 1'b0;
      rf_waddr_o   <= '0;
      rf_wdata_o   <= '0;
      debug_wb_pc  <= '0;
    end else begin
      cnt_q        <= cnt_d;
      rdy_q        <= 1'b1;
      pipe_stall_o <= (state_d == WBA_FORCE);
      rf_wren_o    <= grant_pipe || grant_fifo;
      rf_waddr_o   <= wr_sel.waddr;
      rf_wdata_o   <= wr_sel.wdata;
      debug_wb_pc  <= wr_sel.pc;
    end
  end

  assign debug_wb_rf_wen   = {4{rf_wren_o}};
  assign debug_wb_rf_wnum  = rf_waddr_o;
  assign debug_wb_rf_wdata = rf_wdata_o;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter.
// Inputs change 1ns after posedge; outputs checked there.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        pipe_wren_i;
  logic [4:0]  pipe_waddr_i;
  logic [31:0] pipe_wdata_i;
  logic [31:0] pipe_pc_i;
  logic        lu_valid_i;
  logic        lu_ready_o;
  logic [4:0]  lu_waddr_i;
  logic [31:0] lu_wdata_i;
  logic [31:0] lu_pc_i;
  logic        pipe_stall_o;
  logic        rf_wren_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush_i           (flush_i),
    .pipe_wren_i       (pipe_wren_i),
    .pipe_waddr_i      (pipe_waddr_i),
    .pipe_wdata_i      (pipe_wdata_i),
    .pipe_pc_i         (pipe_pc_i),
    .lu_valid_i        (lu_valid_i),
    .lu_ready_o        (lu_ready_o),
    .lu_waddr_i        (lu_waddr_i),
    .lu_wdata_i        (lu_wdata_i),
    .lu_pc_i           (lu_pc_i),
    .pipe_stall_o      (pipe_stall_o),
    .rf_wren_o         (rf_wren_o),
    .rf_waddr_o        (rf_waddr_o),
    .rf_wdata_o        (rf_wdata_o),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic en, input logic [4:0] a,
                      input logic [31:0] d, input logic [31:0] pc);
    pipe_wren_i  = en;
    pipe_waddr_i = a;
    pipe_wdata_i = d;
    pipe_pc_i    = pc;
  endtask

  task automatic lu(input logic v, input logic [4:0] a,
                    input logic [31:0] d, input logic [31:0] pc);
    lu_valid_i = v;
    lu_waddr_i = a;
    lu_wdata_i = d;
    lu_pc_i    = pc;
  endtask

  initial begin
    rst = 1'b1;
    flush_i = 1'b0;
    pipe(1'b0, 5'd0, 32'd0, 32'd0);
    lu(1'b0, 5'd0, 32'd0, 32'd0);
    step();
    step();
    chk("rst_wren", 32'(rf_wren_o), 32'd0);
    chk("rst_stall", 32'(pipe_stall_o), 32'd0);
    chk("rst_ready", 32'(lu_ready_o), 32'd0);
    chk("rst_dbg_pc", debug_wb_pc, 32'd0);
    chk("rst_dbg_wen", 32'(debug_wb_rf_wen), 32'd0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", 32'(lu_ready_o), 32'd1);

    // Pipe-only write
    pipe(1'b1, 5'd5, 32'h1234, 32'hBFC0_0010);
    step();
    chk("pipe_wren", 32'(rf_wren_o), 32'd1);
    chk("pipe_waddr", 32'(rf_waddr_o), 32'd5);
    chk("pipe_wdata", rf_wdata_o, 32'h1234);
    chk("pipe_dbg_wen", 32'(debug_wb_rf_wen), 32'hF);
    chk("pipe_dbg_pc", debug_wb_pc, 32'hBFC0_0010);
    chk("pipe_dbg_wnum", 32'(debug_wb_rf_wnum), 32'd5);
    chk("pipe_dbg_wdata", debug_wb_rf_wdata, 32'h1234);
    chk("pipe_stall", 32'(pipe_stall_o), 32'd0);
    pipe(1'b0, 5'd0, 32'd0, 32'd0);
    step();
    chk("pipe_idle_wren", 32'(rf_wren_o), 32'd0);

    // Idle-slot drain
    lu(1'b1, 5'd9, 32'hDEAD, 32'h0000_0100);
    step();
    lu(1'b0, 5'd0, 32'd0, 32'd0);
    chk("drain_push_wren", 32'(rf_wren_o), 32'd0);
    step();
    chk("drain_wren", 32'(rf_wren_o), 32'd1);
    chk("drain_waddr", 32'(rf_waddr_o), 32'd9);
    chk("drain_wdata", rf_wdata_o, 32'hDEAD);
    chk("drain_pc", debug_wb_pc, 32'h0000_0100);
    chk("drain_ready", 32'(lu_ready_o), 32'd1);
    step();
    chk("drain_after", 32'(rf_wren_o), 32'd0);

    // Starvation forces one stall cycle
    lu(1'b1, 5'd10, 32'hA5A5, 32'h0000_0200);
    step();
    lu(1'b0, 5'd0, 32'd0, 32'd0);
    pipe(1'b1, 5'd1, 32'h11, 32'h0000_0300);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("starve_pipe%0d", i), 32'(rf_waddr_o), 32'd1);
      chk($sformatf("starve_wren%0d", i), 32'(rf_wren_o), 32'd1);
      chk($sformatf("starve_stall%0d", i), 32'(pipe_stall_o),
          (i == 3) ? 32'd1 : 32'd0);
    end
    step();
    chk("force_waddr", 32'(rf_waddr_o), 32'd10);
    chk("force_wdata", rf_wdata_o, 32'hA5A5);
    chk("force_stall_drop", 32'(pipe_stall_o), 32'd0);
    step();
    chk("resume_waddr", 32'(rf_waddr_o), 32'd1);
    chk("resume_wren", 32'(rf_wren_o), 32'd1);
    chk("resume_stall", 32'(pipe_stall_o), 32'd0);
    pipe(1'b0, 5'd0, 32'd0, 32'd0);
    step();

    // Full FIFO back-pressure and ordering
    pipe(1'b1, 5'd2, 32'h22, 32'h0000_0400);
    lu(1'b1, 5'd11, 32'hB0, 32'h0000_0500);
    step();
    lu(1'b1, 5'd12, 32'hB1, 32'h0000_0504);
    step();
    chk("full_ready0", 32'(lu_ready_o), 32'd0);
    lu(1'b1, 5'd13, 32'hB2, 32'h0000_0508);
    step();
    chk("full_ready1", 32'(lu_ready_o), 32'd0);
    chk("full_pipe_waddr", 32'(rf_waddr_o), 32'd2);
    pipe(1'b0, 5'd0, 32'd0, 32'd0);
    step();
    chk("full_pop0_waddr", 32'(rf_waddr_o), 32'd11);
    chk("full_pop0_wdata", rf_wdata_o, 32'hB0);
    chk("full_ready_again", 32'(lu_ready_o), 32'd1);
    step();
    lu(1'b0, 5'd0, 32'd0, 32'd0);
    chk("full_pop1_waddr", 32'(rf_waddr_o), 32'd12);
    chk("full_pop1_wdata", rf_wdata_o, 32'hB1);
    step();
    chk("full_pop2_waddr", 32'(rf_waddr_o), 32'd13);
    chk("full_pop2_wdata", rf_wdata_o, 32'hB2);
    step();
    chk("full_empty_wren", 32'(rf_wren_o), 32'd0);

    // Flush discards pending results, pipe write commits
    pipe(1'b1, 5'd2, 32'h22, 32'h0000_0600);
    lu(1'b1, 5'd20, 32'hC0, 32'h0000_0700);
    step();
    lu(1'b1, 5'd21, 32'hC1, 32'h0000_0704);
    step();
    lu(1'b0, 5'd0, 32'd0, 32'd0);
    flush_i = 1'b1;
    pipe(1'b1, 5'd3, 32'd7, 32'h0000_0800);
    step();
    flush_i = 1'b0;
    pipe(1'b0, 5'd0, 32'd0, 32'd0);
    chk("flush_wren", 32'(rf_wren_o), 32'd1);
    chk("flush_waddr", 32'(rf_waddr_o), 32'd3);
    chk("flush_wdata", rf_wdata_o, 32'd7);
    chk("flush_stall", 32'(pipe_stall_o), 32'd0);
    chk("flush_ready", 32'(lu_ready_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("flush_no_write%0d", i), 32'(rf_wren_o), 32'd0);
    end

    // Async reset during FORCE
    lu(1'b1, 5'd15, 32'hE0, 32'h0000_0900);
    step();
    lu(1'b0, 5'd0, 32'd0, 32'd0);
    pipe(1'b1, 5'd4, 32'h44, 32'h0000_0A00);
    for (int i = 0; i < 4; i++) step();
    chk("areset_pre_stall", 32'(pipe_stall_o), 32'd1);
    chk("areset_pre_wren", 32'(rf_wren_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("areset_stall", 32'(pipe_stall_o), 32'd0);
    chk("areset_wren", 32'(rf_wren_o), 32'd0);
    pipe(1'b0, 5'd0, 32'd0, 32'd0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("areset_no_write%0d", i), 32'(rf_wren_o), 32'd0);
    end
    chk("areset_ready", 32'(lu_ready_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
